mdu_unit: RTL and testbench
===========================

# mdu_unit

Parametrised multiply/divide unit for the EX stage, the multi-cycle companion to the single-cycle ALU. It executes signed and unsigned multiply and divide over a configurable operand width, holds results in internal HI/LO registers, and supports direct HI/LO writes. A `busy` flag tells the hazard unit to stall dependent HI/LO instructions. A `cancel` input aborts an in-flight operation when the pipeline flushes.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and HI/LO width.
- `MULT_CYCLES`, default 5: multiply latency in cycles. Must be ≥1.
- `DIV_CYCLES`, default 10: divide latency in cycles. Must be ≥1.

**Ports**
- `clk`, input, 1: clock. All state changes on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: launch the operation in `op` this cycle.
- `op`, input, 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU. All other codes are a no-op.
- `S1`, input, WIDTH: operand A (rs). Also the data source for MTHI/MTLO.
- `S2`, input, WIDTH: operand B (rt).
- `cancel`, input, 1: abort the in-flight operation.
- `busy`, output, 1: an operation is in flight.
- `HI`, output, WIDTH: HI register.
- `LO`, output, WIDTH: LO register.

## Operation

**State machine:** IDLE, MUL, DIV.
- IDLE → MUL on `start` with op 0/1 (or 6–9 when enabled).
- IDLE → DIV on `start` with op 2/3.
- MUL/DIV → IDLE when the countdown reaches 1, or on `cancel`.

**Latching:** operands and op are latched at the start edge. Later changes on `S1`/`S2` have no effect.

**Multiply**
- Full 2·WIDTH product; {HI,LO} ← product.
- MULT is signed; MULTU is unsigned.

**Divide**
- LO ← quotient, truncated toward zero. HI ← remainder, which takes the sign of the dividend.
- Divide by zero: LO ← all ones, HI ← dividend.
- Signed overflow (−2^(WIDTH−1) / −1): LO ← −2^(WIDTH−1), HI ← 0.

**MTHI/MTLO**
- Accepted only in IDLE; single-cycle, `busy` stays 0.
- HI (or LO) ← `S1` at the start edge. The other register is unchanged.

**Ignored requests**
- `start` while `busy`=1 is ignored. The requester must hold off; this is the hazard unit's job.
- Undefined op codes leave all state unchanged.

**Cancel**
- `cancel`=1 in MUL/DIV returns to IDLE at that edge. HI/LO keep their pre-operation values.
- `cancel` has priority over a completion on the same edge.
- `cancel` in IDLE has no effect, and a `start` in that cycle is also dropped.

**Reset:** `reset_n`=0 forces IDLE, `busy`=0, HI=0, LO=0, and clears the counter. This holds mid-operation and overrides `start`/`cancel`.

**Internal implementation:** free; combinational product/quotient plus a delay counter is acceptable. Only the externally visible latency is normative.

## Timing

- `start` sampled at edge E0 for a mult/div:
  - `busy`=1 from after E0 until edge E_N, where N = MULT_CYCLES or DIV_CYCLES.
  - At E_N, HI/LO update and `busy` falls together.
  - Results are visible in the cycle after E_N.
- A new `start` is accepted in the cycle where `busy` has just fallen, giving back-to-back throughput of one op per N+1 cycles.
- MTHI/MTLO: value is visible the cycle after the start edge.
- HI/LO never change while `busy`=1. Mid-operation reads return the old values.

## Configuration

- `MDU_MADD_EN` defined:
  - op 6/7 (MADD/MADDU): {HI,LO} ← {HI,LO} + S1×S2.
  - op 8/9 (MSUB/MSUBU): {HI,LO} ← {HI,LO} − S1×S2.
  - Accumulation is mod 2^(2·WIDTH) using the HI/LO values at completion. Latency is MULT_CYCLES.
- Not defined: op 6–9 decode as no-ops, and the accumulate datapath is absent.

## Test plan

- **Reset and MULT:** reset, then MULT S1=0xFFFFFFFE, S2=3.
  - `busy` high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **MULTU/DIV sequence:** MULTU 0xFFFFFFFF×0xFFFFFFFF, then back-to-back DIV −7/2.
  - After MULTU: HI=0xFFFFFFFE, LO=0x00000001.
  - DIV start accepted the cycle `busy` falls. After it: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide edge cases:**
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Cancel:** MTLO 0x1234, then DIV 100/3, with `cancel` asserted 4 cycles in.
  - `busy` drops the next cycle.
  - LO stays 0x1234 and HI is unchanged.
  - A `start` during `busy` is ignored.
- **Reset mid-operation:** `reset_n`=0 during a MULT.
  - HI=LO=0 and `busy`=0 the next cycle.
  - No late completion occurs.
- **Accumulate (with `MDU_MADD_EN`):** HI=0, LO=0xFFFFFFFF, then MADDU 1×1.
  - Result HI=1, LO=0.
  - Without the macro, the same op leaves HI/LO unchanged.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, cancel and MTHI/MTLO.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are built when MDU_MADD_EN is defined.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] S1,
    input  logic [WIDTH-1:0] S2,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    function automatic logic f_is_mul(input logic [3:0] o);
        logic v;
        v = (o == OP_MULT) || (o == OP_MULTU);
`ifdef MDU_MADD_EN
        v = v || (o == OP_MADD) || (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
`endif
        return v;
    endfunction

    state_e             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               w_launch, w_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start && !cancel) begin
                if (f_is_mul(op))                        w_state_next = S_MUL;
                else if (op == OP_DIV || op == OP_DIVU)  w_state_next = S_DIV;
            end
            S_MUL, S_DIV: if (cancel || r_cnt == CNT_W'(1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Cancel wins over a same-edge completion; cancel in IDLE also drops start.
    always_comb begin
        busy     = (r_state != S_IDLE);
        w_launch = (r_state == S_IDLE) && start && !cancel;
        w_done   = (r_state != S_IDLE) && !cancel && (r_cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_launch && f_is_mul(op)) begin
            r_cnt <= CNT_W'(MULT_CYCLES);
            r_op  <= op;
            r_a   <= S1;
            r_b   <= S2;
        end else if (w_launch && (op == OP_DIV || op == OP_DIVU)) begin
            r_cnt <= CNT_W'(DIV_CYCLES);
            r_op  <= op;
            r_a   <= S1;
            r_b   <= S2;
        end else if (busy) begin
            r_cnt <= (cancel || r_cnt == CNT_W'(1)) ? '0 : r_cnt - CNT_W'(1);
        end
    end

    // Operand datapath works on latched operands only.
    logic                 w_signed, w_neg_a, w_neg_b;
    logic [2*WIDTH-1:0]   w_ax, w_bx, w_prod, w_result;
    logic [WIDTH-1:0]     w_abs_a, w_abs_b, w_quo_u, w_rem_u, w_quo, w_rem, w_div_hi, w_div_lo;

    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV) || (r_op == OP_MADD) || (r_op == OP_MSUB);
    assign w_ax     = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_bx     = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod   = w_ax * w_bx;

    assign w_neg_a  = w_signed & r_a[WIDTH-1];
    assign w_neg_b  = w_signed & r_b[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -r_a : r_a;
    assign w_abs_b  = w_neg_b ? -r_b : r_b;
    assign w_quo_u  = (w_abs_b == '0) ? '0 : w_abs_a / w_abs_b;
    assign w_rem_u  = (w_abs_b == '0) ? '0 : w_abs_a % w_abs_b;
    assign w_quo    = (w_neg_a ^ w_neg_b) ? -w_quo_u : w_quo_u;
    assign w_rem    = w_neg_a ? -w_rem_u : w_rem_u;
    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) wraps back to itself.
    assign w_div_lo = (r_b == '0) ? '1  : w_quo;
    assign w_div_hi = (r_b == '0) ? r_a : w_rem;

    always_comb begin
        w_result = w_prod;
        case (r_op)
            OP_DIV, OP_DIVU:   w_result = {w_div_hi, w_div_lo};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: w_result = {r_hi, r_lo} + w_prod;
            OP_MSUB, OP_MSUBU: w_result = {r_hi, r_lo} - w_prod;
`endif
            default:           w_result = w_prod;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            {r_hi, r_lo} <= w_result;
        end else if (w_launch && op == OP_MTHI) begin
            r_hi <= S1;
        end else if (w_launch && op == OP_MTLO) begin
            r_lo <= S1;
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: scoreboard of expected {HI,LO} pushed at launch, popped at completion.
// Expectations for MADD depend on MDU_MADD_EN, matching the build of the design.
module tb_mdu_unit;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic          clk = 1'b0;
    logic          reset_n, start, cancel;
    logic [3:0]    op;
    logic [W-1:0]  s1, s2, hi, lo;
    logic          busy;

    int            checks   = 0;
    int            failures = 0;
    logic [63:0]   sb_q[$];

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .S1      (s1),
        .S2      (s2),
        .cancel  (cancel),
        .busy    (busy),
        .HI      (hi),
        .LO      (lo)
    );

    // Independent reference: native SV signed/unsigned arithmetic with explicit corner cases.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] r;
        sa = a;
        sb = b;
        r  = 64'h0;
        case (o)
            4'd0: begin sp = longint'(sa) * longint'(sb); r = sp; end
            4'd1: r = {32'h0, a} * {32'h0, b};
            4'd2: begin
                if (b == 0)                           r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && sb == -1) r = {32'h0, a};
                else                                  r = {32'(sa % sb), 32'(sa / sb)};
            end
            4'd3: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else        r = {a % b, a / b};
            end
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit push);
        start = 1'b1;
        op    = o;
        s1    = a;
        s2    = b;
        if (push) sb_q.push_back(exp);
        step();
        start = 1'b0;
        s1    = $urandom;
        s2    = $urandom;
    endtask

    task automatic drain(output int n);
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        cancel  = 1'b0;
        op      = 4'd0;
        s1      = 32'h1234_5678;
        s2      = 32'h9;
        step();
        step();
        checks++;
        if ({busy, hi, lo} !== {1'b0, 64'h0})
            $display("FAIL reset_state got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
        else failures += 0;
        if ({busy, hi, lo} !== {1'b0, 64'h0}) failures++;
        start   = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int n;
        logic [63:0] exp;
        launch(4'd0, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        checks++;
        if (busy !== 1'b1 || {hi, lo} !== 64'h0) begin
            failures++;
            $display("FAIL mult_inflight got busy=%b hi=%h lo=%h want busy=1 hi=0 lo=0", busy, hi, lo);
        end
        drain(n);
        checks++;
        if (n !== MC) begin
            failures++;
            $display("FAIL mult_latency got %0d want %0d", n, MC);
        end
        exp = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL mult_result got %h want %h", {hi, lo}, exp);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [63:0] exp;
        launch(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        drain(n);
        exp = sb_q.pop_front();
        checks++;
        if (n !== MC || {hi, lo} !== exp) begin
            failures++;
            $display("FAIL multu_result got cyc=%0d %h want cyc=%0d %h", n, {hi, lo}, MC, exp);
        end
        launch(4'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL div_b2b_accept got busy=%b want 1", busy);
        end
        drain(n);
        checks++;
        if (n !== DC) begin
            failures++;
            $display("FAIL div_latency got %0d want %0d", n, DC);
        end
        exp = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL div_neg_result got %h want %h", {hi, lo}, exp);
        end
    endtask

    task automatic test_div_edge();
        int n;
        logic [63:0] exp;
        launch(4'd3, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1);
        drain(n);
        exp = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL divu_by_zero got %h want %h", {hi, lo}, exp);
        end
        launch(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        drain(n);
        exp = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL div_overflow got %h want %h", {hi, lo}, exp);
        end
    endtask

    task automatic test_random();
        int n;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            launch(o, a, b, model(o, a, b), 1'b1);
            drain(n);
            exp = sb_q.pop_front();
            checks++;
            if (n !== ((o < 4'd2) ? MC : DC) || {hi, lo} !== exp) begin
                failures++;
                $display("FAIL random_op%0d a=%h b=%h got cyc=%0d %h want %h", o, a, b, n, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] hi_before;
        hi_before = hi;
        launch(4'd5, 32'h0000_1234, 32'h0, 64'h0, 1'b0);
        checks++;
        if (busy !== 1'b0 || lo !== 32'h0000_1234 || hi !== hi_before) begin
            failures++;
            $display("FAIL mtlo got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=00001234", busy, hi, lo, hi_before);
        end
        launch(4'd2, 32'd100, 32'd3, 64'h0, 1'b0);
        step();
        start = 1'b1; op = 4'd4; s1 = 32'hDEAD_BEEF;
        step();
        start = 1'b0;
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || lo !== 32'h0000_1234 || hi !== hi_before) begin
            failures++;
            $display("FAIL cancel got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=00001234", busy, hi, lo, hi_before);
        end
        for (int i = 0; i < DC + 2; i++) step();
        checks++;
        if (busy !== 1'b0 || lo !== 32'h0000_1234 || hi !== hi_before) begin
            failures++;
            $display("FAIL cancel_no_late got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=00001234", busy, hi, lo, hi_before);
        end
        cancel = 1'b1;
        launch(4'd4, 32'hCAFE_F00D, 32'h0, 64'h0, 1'b0);
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== hi_before) begin
            failures++;
            $display("FAIL cancel_idle_drop got busy=%b hi=%h want busy=0 hi=%h", busy, hi, hi_before);
        end
    endtask

    task automatic test_reset_mid();
        launch(4'd0, 32'd3, 32'd5, 64'h0, 1'b0);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
            failures++;
            $display("FAIL reset_mid got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
        end
        for (int i = 0; i < MC + 2; i++) step();
        checks++;
        if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
            failures++;
            $display("FAIL reset_no_late got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
        end
    endtask

    task automatic test_madd();
        int n;
        logic [63:0] exp;
        launch(4'd4, 32'h0, 32'h0, 64'h0, 1'b0);
        launch(4'd5, 32'hFFFF_FFFF, 32'h0, 64'h0, 1'b0);
`ifdef MDU_MADD_EN
        launch(4'd7, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 1'b1);
        drain(n);
        checks++;
        if (n !== MC) begin
            failures++;
            $display("FAIL maddu_latency got %0d want %0d", n, MC);
        end
`else
        launch(4'd7, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL maddu_noop_busy got %b want 0", busy);
        end
        drain(n);
`endif
        exp = sb_q.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            failures++;
            $display("FAIL maddu_result got %h want %h", {hi, lo}, exp);
        end
        launch(4'd15, 32'h5555_5555, 32'h3, 64'h0, 1'b0);
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== exp) begin
            failures++;
            $display("FAIL undefined_op got busy=%b %h want busy=0 %h", busy, {hi, lo}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div_edge();
        test_random();
        test_cancel();
        test_reset_mid();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
